// File: rtl/mul_pkg.sv
// mul_pkg: shared constants and helpers for the sequential multiply controller.
package mul_pkg;
    localparam int MUL_DW = 32;
    localparam int MUL_PW = 64;
    localparam int MUL_LAT = 6;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    // The most negative value maps onto itself, which is the correct unsigned magnitude.
    function automatic logic [MUL_DW-1:0] abs_dw(input logic [MUL_DW-1:0] x);
        return x[MUL_DW-1] ? -x : x;
    endfunction
endpackage

// File: rtl/mul_seq_ctrl_if.sv
// mul_seq_ctrl_if: issue/result handshake between EX-stage issue logic and the multiply controller.
interface mul_seq_ctrl_if import mul_pkg::*; #(parameter int DW = MUL_DW);
    logic start_i;
    logic signed_i;
    logic cancel_i;
    logic [DW-1:0] a_i;
    logic [DW-1:0] b_i;
    logic ready_o;
    logic busy_o;
    logic done_o;
    logic [DW-1:0] hi_o;
    logic [DW-1:0] lo_o;
    modport master(output start_i, signed_i, cancel_i, a_i, b_i,
                   input ready_o, busy_o, done_o, hi_o, lo_o);
    modport slave(input start_i, signed_i, cancel_i, a_i, b_i,
                  output ready_o, busy_o, done_o, hi_o, lo_o);
endinterface

// File: rtl/mul2.sv
// mul2: 16x16 unsigned combinational multiplier.
module mul2 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] p
);
    assign p = a * b;
endmodule

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: 32x32 MULT/MULTU built from four 16x16 partial products on one shared multiplier.
module mul_seq_ctrl import mul_pkg::*; #(
    parameter int DW = MUL_DW,
    parameter int PW = MUL_PW
) (
    input logic clk,
    input logic rst,
    mul_seq_ctrl_if.slave bus
);
    logic [1:0] state;
    logic [1:0] cnt;
    logic [DW-1:0] mag_a;
    logic [DW-1:0] mag_b;
    logic [DW-1:0] pp;
    logic neg;
    logic [PW-1:0] acc;
    logic [PW-1:0] pp_sh;
    logic [PW-1:0] prod;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [5:0] sh;
    logic ready;

    // cnt[1] selects the high half of a, cnt[0] the high half of b.
    always_comb begin
        op_a = cnt[1] ? mag_a[31:16] : mag_a[15:0];
        op_b = cnt[0] ? mag_b[31:16] : mag_b[15:0];
        sh = (cnt == 2'd0) ? 6'd0 : (cnt == 2'd3) ? 6'd32 : 6'd16;
        pp_sh = {{(PW-DW){1'b0}}, pp} << sh;
        prod = neg ? ~acc + PW'(1) : acc;
    end

    mul2 u_mul2 (.a(op_a), .b(op_b), .p(pp));

    assign ready = (state == S_IDLE) || (state == S_DONE);
    assign bus.ready_o = ready;
    assign bus.busy_o = !ready;
    assign bus.done_o = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt <= 2'd0;
            acc <= '0;
            mag_a <= '0;
            mag_b <= '0;
            neg <= 1'b0;
            bus.hi_o <= '0;
            bus.lo_o <= '0;
        end else if (bus.cancel_i) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start_i) begin
                        mag_a <= bus.signed_i ? abs_dw(bus.a_i) : bus.a_i;
                        mag_b <= bus.signed_i ? abs_dw(bus.b_i) : bus.b_i;
                        neg <= bus.signed_i & (bus.a_i[DW-1] ^ bus.b_i[DW-1]);
                        acc <= '0;
                        cnt <= 2'd0;
                        state <= S_CALC;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    acc <= acc + pp_sh;
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) state <= S_FIX;
                end
                S_FIX: begin
                    {bus.hi_o, bus.lo_o} <= prod;
                    state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: directed and randomized checks of the multiply controller against a 64-bit arithmetic model.
module tb_mul_seq_ctrl;
    import mul_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    mul_seq_ctrl_if bus();
    mul_seq_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
        bus.a_i = a;
        bus.b_i = b;
        bus.signed_i = s;
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 1;
        while (!bus.done_o && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic count_done(input int cycles, output int d);
        d = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (bus.done_o) d++;
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa;
        longint sb;
        logic [63:0] ua;
        logic [63:0] ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        return s ? 64'(sa * sb) : ua * ub;
    endfunction

    task automatic test_reset;
        checks++;
        if (bus.ready_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got r=%b b=%b d=%b want 1 0 0", bus.ready_o, bus.busy_o, bus.done_o);
        end
        checks++;
        if (bus.hi_o !== 32'd0 || bus.lo_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_hilo got %h_%h want 0_0", bus.hi_o, bus.lo_o);
        end
    endtask

    task automatic test_directed;
        logic [31:0] ta [3] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000};
        logic [31:0] tb [3] = '{32'hFFFFFFFF, 32'h00000005, 32'h80000000};
        logic ts [3] = '{1'b0, 1'b1, 1'b1};
        logic [63:0] te [3] = '{64'hFFFFFFFE_00000001, 64'hFFFFFFFF_FFFFFFF1, 64'h40000000_00000000};
        int n;
        for (int i = 0; i < 3; i++) begin
            issue(ta[i], tb[i], ts[i]);
            checks++;
            if (bus.busy_o !== 1'b1 || bus.ready_o !== 1'b0) begin
                errors++;
                $display("FAIL dir%0d_busy got busy=%b ready=%b want 1 0", i, bus.busy_o, bus.ready_o);
            end
            wait_done(n);
            checks++;
            if (n !== MUL_LAT) begin
                errors++;
                $display("FAIL dir%0d_latency got %0d want %0d", i, n, MUL_LAT);
            end
            checks++;
            if ({bus.hi_o, bus.lo_o} !== te[i]) begin
                errors++;
                $display("FAIL dir%0d_result got %h_%h want %h", i, bus.hi_o, bus.lo_o, te[i]);
            end
            step();
            checks++;
            if (bus.done_o !== 1'b0 || bus.ready_o !== 1'b1) begin
                errors++;
                $display("FAIL dir%0d_pulse got done=%b ready=%b want 0 1", i, bus.done_o, bus.ready_o);
            end
        end
    endtask

    task automatic test_back_to_back;
        int n;
        issue(32'h00012345, 32'h0, 1'b1);
        wait_done(n);
        checks++;
        if ({bus.hi_o, bus.lo_o} !== 64'd0 || n !== MUL_LAT) begin
            errors++;
            $display("FAIL b2b_first got %h_%h n=%0d want 0_0 n=%0d", bus.hi_o, bus.lo_o, n, MUL_LAT);
        end
        issue(32'd7, 32'd6, 1'b0);
        wait_done(n);
        checks++;
        if (n !== MUL_LAT || bus.lo_o !== 32'd42 || bus.hi_o !== 32'd0) begin
            errors++;
            $display("FAIL b2b_second got n=%0d %h_%h want n=%0d 0_2a", n, bus.hi_o, bus.lo_o, MUL_LAT);
        end
        step();
    endtask

    task automatic test_busy_ignore;
        int n;
        int d;
        issue(32'd2, 32'd3, 1'b0);
        bus.a_i = 32'd9;
        bus.b_i = 32'd9;
        bus.start_i = 1'b1;
        wait_done(n);
        bus.start_i = 1'b0;
        checks++;
        if (n !== MUL_LAT || bus.lo_o !== 32'd6 || bus.hi_o !== 32'd0) begin
            errors++;
            $display("FAIL busy_ignore got n=%0d %h_%h want n=%0d 0_6", n, bus.hi_o, bus.lo_o, MUL_LAT);
        end
        count_done(8, d);
        checks++;
        if (d !== 0) begin
            errors++;
            $display("FAIL busy_queued got %0d extra done want 0", d);
        end
    endtask

    task automatic test_cancel;
        int d;
        issue($urandom, $urandom, 1'b0);
        step();
        step();
        bus.cancel_i = 1'b1;
        step();
        bus.cancel_i = 1'b0;
        checks++;
        if (bus.ready_o !== 1'b1 || bus.done_o !== 1'b0 || bus.hi_o !== 32'd0 || bus.lo_o !== 32'd6) begin
            errors++;
            $display("FAIL cancel_calc got r=%b d=%b %h_%h want 1 0 0_6", bus.ready_o, bus.done_o, bus.hi_o, bus.lo_o);
        end
        count_done(8, d);
        checks++;
        if (d !== 0) begin
            errors++;
            $display("FAIL cancel_calc_done got %0d done want 0", d);
        end
        issue(32'h1234, 32'h5678, 1'b0);
        for (int i = 0; i < 4; i++) step();
        bus.cancel_i = 1'b1;
        step();
        bus.cancel_i = 1'b0;
        count_done(6, d);
        checks++;
        if (d !== 0 || bus.ready_o !== 1'b1 || bus.hi_o !== 32'd0 || bus.lo_o !== 32'd6) begin
            errors++;
            $display("FAIL cancel_fix got done=%0d r=%b %h_%h want 0 1 0_6", d, bus.ready_o, bus.hi_o, bus.lo_o);
        end
    endtask

    task automatic test_reset_mid;
        issue(32'd5, 32'd7, 1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (bus.ready_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.hi_o !== 32'd0 || bus.lo_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid got r=%b b=%b d=%b %h_%h want 1 0 0 0_0", bus.ready_o, bus.busy_o, bus.done_o, bus.hi_o, bus.lo_o);
        end
    endtask

    task automatic test_cancel_start;
        int d;
        bus.a_i = 32'd3;
        bus.b_i = 32'd3;
        bus.start_i = 1'b1;
        bus.cancel_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        bus.cancel_i = 1'b0;
        checks++;
        if (bus.ready_o !== 1'b1 || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL cancel_start got r=%b b=%b want 1 0", bus.ready_o, bus.busy_o);
        end
        count_done(8, d);
        checks++;
        if (d !== 0 || bus.lo_o !== 32'd0) begin
            errors++;
            $display("FAIL cancel_start_done got done=%0d lo=%h want 0 0", d, bus.lo_o);
        end
    endtask

    task automatic test_random;
        logic [31:0] corner [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
        logic [31:0] a;
        logic [31:0] b;
        logic s;
        logic [63:0] exp;
        int n;
        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            s = 1'($urandom_range(0, 1));
            exp = model(a, b, s);
            issue(a, b, s);
            bus.a_i = $urandom;
            bus.b_i = $urandom;
            wait_done(n);
            checks++;
            if (n !== MUL_LAT || {bus.hi_o, bus.lo_o} !== exp) begin
                errors++;
                $display("FAIL rand%0d a=%h b=%h s=%b got n=%0d %h_%h want n=%0d %h", i, a, b, s, n, bus.hi_o, bus.lo_o, MUL_LAT, exp);
            end
            if ($urandom_range(0, 1) == 0) step();
        end
    endtask

    initial begin
        bus.start_i = 1'b0;
        bus.signed_i = 1'b0;
        bus.cancel_i = 1'b0;
        bus.a_i = '0;
        bus.b_i = '0;
        step();
        step();
        rst = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_busy_ignore();
        test_cancel();
        test_reset_mid();
        test_cancel_start();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Multi-cycle 32x32 multiply controller for the MIPS MULT/MULTU path.
- Time-shares one 16x16 unsigned combinational multiplier (mul2) across four partial-product cycles and accumulates a 64-bit product.
- Applies the sign fix-up for signed operands and delivers the HI/LO result with a start/done handshake.
- Sits between the EX-stage issue logic and the HI/LO registers; supports pipeline flush via cancel.

Parameters:
- DW, 32, operand width; only 32 is supported (operands split into two 16-bit halves).
- PW, 64, product/accumulator width, fixed at 2*DW.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  request a multiply; sampled only when ready_o=1.
- signed_i  in  1  1=MULT (two's complement), 0=MULTU; sampled with start_i.
- a_i  in  32  multiplicand; sampled with start_i.
- b_i  in  32  multiplier; sampled with start_i.
- cancel_i  in  1  flush; aborts any in-flight operation.
- ready_o  out  1  1 in IDLE or DONE; start accepted only then.
- busy_o  out  1  1 in CALC or FIX.
- done_o  out  1  one-cycle pulse; hi_o/lo_o valid in that cycle.
- hi_o  out  32  product[63:32].
- lo_o  out  32  product[31:0].

Behaviour:
- Reset (sync, rst=1 at edge): state=IDLE, cnt=0, acc=0, hi_o=0, lo_o=0, done_o=0, busy_o=0, ready_o=1. Reset wins over start_i and cancel_i.
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE with start_i=1 and cancel_i=0:
  - latch mag_a=|a_i|, mag_b=|b_i| if signed_i, else raw operands;
  - latch neg = signed_i & (a_i[31] ^ b_i[31]);
  - clear acc; set cnt=0; go CALC.
- IDLE/DONE without start: DONE -> IDLE; IDLE stays.
- CALC, one partial product per cycle, cnt 0..3, fed to the mul2 instance:
  - cnt0: mag_a[15:0] * mag_b[15:0], added at bit 0;
  - cnt1: mag_a[15:0] * mag_b[31:16], added at bit 16;
  - cnt2: mag_a[31:16] * mag_b[15:0], added at bit 16;
  - cnt3: mag_a[31:16] * mag_b[31:16], added at bit 32.
  - All adds are 64-bit unsigned with no overflow possible. cnt3 -> FIX.
- FIX: product = neg ? (~acc + 1) : acc. Register it into {hi_o, lo_o}; go DONE.
- DONE: done_o=1 for exactly this cycle.
- Latency: start sampled at edge E0; CALC occupies cycles 1-4; FIX is cycle 5; done_o=1 in cycle 6. Back-to-back issue from DONE yields one result every 6 cycles.
- hi_o/lo_o:
  - hold their value from FIX until the next FIX;
  - are not cleared by start;
  - are not changed by cancel.
- Magnitude rule: |0x80000000| = 0x80000000, taken as unsigned 32 bits (no overflow).
- start_i while busy_o=1 is ignored and not queued.
- cancel_i=1 in any state -> IDLE next cycle:
  - done_o=0 and no write to hi_o/lo_o;
  - cancel in FIX suppresses that result's update;
  - cancel and start in the same cycle: cancel wins and start is dropped.
- Invariants: ready_o == (state in {IDLE, DONE}); busy_o == ~ready_o; done_o == (state == DONE).
- Operand registers are internal; a_i/b_i may change freely after acceptance.

Decomposition:
- Shared package (mul_pkg):
  - state encoding constants S_IDLE=2'd0, S_CALC=2'd1, S_FIX=2'd2, S_DONE=2'd3;
  - MUL_DW=32, MUL_PW=64, MUL_LAT=6.
- One sub-module: a single instance of the existing 16x16 unsigned combinational multiplier mul2.
- The half-operand selection muxes and the 64-bit accumulator stay in mul_seq_ctrl.

Test Plan:
- Unsigned a=0xFFFFFFFF, b=0xFFFFFFFF -> done_o in cycle 6 after start, hi=0xFFFFFFFE, lo=0x00000001.
- Signed a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Signed a=b=0x80000000 -> hi=0x40000000, lo=0x00000000.
- Signed a=0x00012345, b=0x00000000 -> hi=0, lo=0, neg irrelevant. Then a back-to-back start asserted in the DONE cycle (a=7, b=6 unsigned) -> second done_o exactly 6 cycles later with lo=42.
- Start a=2, b=3; start_i held high with a=9, b=9 during busy -> only one done_o, lo=6. cancel_i in cycle 3 of a new op -> no done_o, hi/lo still hold 0/6, ready_o=1 the next cycle.
- rst asserted in CALC -> next cycle state IDLE, hi/lo=0, done_o=0. cancel_i and start_i together in IDLE -> op not started, ready_o stays 1.
